// File: rtl/prm_sweep_pkg.sv
// Shared types and constants for the PRM edge-sweep controller.
package prm_sweep_pkg;

    localparam int VOX_W_DEF = 15;
    localparam int CNT_W_DEF = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SWEEP = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sweep_state_e;

endpackage

// File: rtl/prm_mask_accum.sv
// Sticky OR-accumulator of per-edge collision masks plus a saturating
// count of evaluated voxels.
module prm_mask_accum
    import prm_sweep_pkg::*;
#(
    parameter int N_EDGE = 1024,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              acc_en_i,
    input  logic [N_EDGE-1:0] mask_i,
    output logic [N_EDGE-1:0] mask_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_EDGE-1:0] mask_q;
    logic [CNT_W-1:0]  count_q;

    // Mask bits only ever set within a sweep; count sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            mask_q  <= '0;
            count_q <= '0;
        end else if (acc_en_i) begin
            mask_q <= mask_q | mask_i;
            if (count_q != CNT_SAT) begin
                count_q <= count_q + CNT_ONE;
            end
        end
    end

    assign mask_o  = mask_q;
    assign count_o = count_q;

endmodule

// File: rtl/prm_edge_sweep_ctrl.sv
// Drives a stream of occupied-voxel codes into a combinational checker bank
// and hands the accumulated per-edge blocked mask to the planner.
module prm_edge_sweep_ctrl
    import prm_sweep_pkg::*;
#(
    parameter int VOX_W  = VOX_W_DEF,
    parameter int N_EDGE = 1024,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    input  logic              vox_valid,
    output logic              vox_ready,
    input  logic [VOX_W-1:0]  vox_code,
    input  logic              vox_last,
    output logic [VOX_W-1:0]  chk_vox,
    input  logic [N_EDGE-1:0] chk_mask,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N_EDGE-1:0] res_mask,
    output logic [CNT_W-1:0]  res_count
);

    sweep_state_e     state_q;
    logic             busy_q;
    logic             vox_ready_q;
    logic             res_valid_q;
    logic             eval_v_q;
    logic [VOX_W-1:0] chk_vox_q;

    logic vox_hs_s;
    logic acc_clr_s;
    logic acc_en_s;

    assign vox_hs_s = vox_valid & vox_ready_q;
    // An abort cancels both the clear and whatever evaluation is in flight.
    assign acc_clr_s = (state_q == ST_CLEAR) & ~abort;
    assign acc_en_s  = eval_v_q & ~abort;

    // Sweep sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            vox_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            eval_v_q    <= 1'b0;
            chk_vox_q   <= '0;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            vox_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            eval_v_q    <= 1'b0;
        end else begin
            eval_v_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_q     <= ST_SWEEP;
                    vox_ready_q <= 1'b1;
                end
                ST_SWEEP: begin
                    if (vox_hs_s) begin
                        chk_vox_q <= vox_code;
                        eval_v_q  <= 1'b1;
                        if (vox_last) begin
                            state_q     <= ST_DRAIN;
                            vox_ready_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q     <= ST_DONE;
                    res_valid_q <= 1'b1;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    vox_ready_q <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    prm_mask_accum #(
        .N_EDGE (N_EDGE),
        .CNT_W  (CNT_W)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (acc_clr_s),
        .acc_en_i (acc_en_s),
        .mask_i   (chk_mask),
        .mask_o   (res_mask),
        .count_o  (res_count)
    );

    assign busy      = busy_q;
    assign vox_ready = vox_ready_q;
    assign res_valid = res_valid_q;
    assign chk_vox   = chk_vox_q;

endmodule

// File: tb/tb_prm_edge_sweep_ctrl.sv
// Scoreboard bench for prm_edge_sweep_ctrl with an 8-edge behavioural bank
// whose mask is the low byte of the driven voxel code.
module tb_prm_edge_sweep_ctrl;

    localparam int VW = 15;
    localparam int NE = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          vox_valid = 1'b0;
    logic          vox_last = 1'b0;
    logic          res_ready = 1'b0;
    logic [VW-1:0] vox_code = '0;
    logic          busy, vox_ready, res_valid;
    logic [VW-1:0] chk_vox;
    logic [NE-1:0] chk_mask, res_mask;
    logic [CW-1:0] res_count;

    typedef struct packed {
        logic [NE-1:0] mask;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    prm_edge_sweep_ctrl #(.VOX_W(VW), .N_EDGE(NE), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .vox_valid (vox_valid),
        .vox_ready (vox_ready),
        .vox_code  (vox_code),
        .vox_last  (vox_last),
        .chk_vox   (chk_vox),
        .chk_mask  (chk_mask),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_mask  (res_mask),
        .res_count (res_count)
    );

    assign chk_mask = chk_vox[7:0];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every cycle a result is presented it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL res_unexpected: got res_valid=1 expected no result pending");
            end else begin
                check("sb_res_mask", {24'd0, res_mask}, {24'd0, exp_q[0].mask});
                check("sb_res_count", {28'd0, res_count}, {28'd0, exp_q[0].cnt});
                if (res_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic send(input logic [VW-1:0] code, input logic last);
        vox_valid = 1'b1;
        vox_code  = code;
        vox_last  = last;
        tick();
        vox_valid = 1'b0;
        vox_last  = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n = 0;
        while (!res_valid && n < 10) begin
            tick();
            n++;
        end
        check(name, {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VW-1:0] c;

        // Reset state
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_vox_ready", {31'd0, vox_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_chk_vox", {17'd0, chk_vox}, 32'd0);
        check("rst_res_count", {28'd0, res_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single sweep with exact latency
        res_ready = 1'b1;
        exp_q.push_back('{mask: 8'h93, cnt: 4'd3});
        begin_sweep();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_vox_ready", {31'd0, vox_ready}, 32'd1);
        send(15'h0003, 1'b0);
        send(15'h0010, 1'b0);
        send(15'h0080, 1'b1);
        check("t1_drain_valid", {31'd0, res_valid}, 32'd0);
        check("t1_drain_ready", {31'd0, vox_ready}, 32'd0);
        tick();
        check("t1_latency", {31'd0, res_valid}, 32'd1);
        tick();
        check("t1_valid_off", {31'd0, res_valid}, 32'd0);
        check("t1_busy_off", {31'd0, busy}, 32'd0);
        check("t1_mask_hold", {24'd0, res_mask}, 32'h93);

        // Back-to-back stream, no bubbles
        exp_q.push_back('{mask: 8'h1F, cnt: 4'd5});
        begin_sweep();
        for (int i = 0; i < 5; i++) begin
            check("t2_ready", {31'd0, vox_ready}, 32'd1);
            c = '0;
            c[i] = 1'b1;
            send(c, (i == 4));
        end
        wait_result("t2_valid");
        tick();

        // Gaps and result backpressure
        res_ready = 1'b0;
        exp_q.push_back('{mask: 8'h61, cnt: 4'd2});
        begin_sweep();
        send(15'h0021, 1'b0);
        tick();
        send(15'h0040, 1'b1);
        wait_result("t3_valid");
        for (int i = 0; i < 4; i++) begin
            check("t3_hold_valid", {31'd0, res_valid}, 32'd1);
            check("t3_hold_mask", {24'd0, res_mask}, 32'h61);
            tick();
        end
        res_ready = 1'b1;
        tick();
        check("t3_busy_off", {31'd0, busy}, 32'd0);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t4_idle_abort_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t4_idle_abort_ready", {31'd0, vox_ready}, 32'd0);

        // Abort mid-sweep with the second voxel still in flight
        begin_sweep();
        send(15'h0005, 1'b0);
        send(15'h000A, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_busy", {31'd0, busy}, 32'd0);
        check("t4_abort_ready", {31'd0, vox_ready}, 32'd0);
        check("t4_abort_count", {28'd0, res_count}, 32'd1);
        check("t4_abort_mask", {24'd0, res_mask}, 32'h05);
        tick();
        tick();
        exp_q.push_back('{mask: 8'h04, cnt: 4'd1});
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t4_clear_mask", {24'd0, res_mask}, 32'd0);
        check("t4_clear_count", {28'd0, res_count}, 32'd0);
        send(15'h0004, 1'b1);
        wait_result("t4_valid");
        tick();

        // Counter saturation
        exp_q.push_back('{mask: 8'h00, cnt: 4'd15});
        begin_sweep();
        for (int i = 0; i < 20; i++) begin
            send(15'h0000, (i == 19));
        end
        wait_result("t5_valid");
        tick();

        // Asynchronous reset in the middle of a sweep
        begin_sweep();
        send(15'h000F, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_vox_ready", {31'd0, vox_ready}, 32'd0);
        check("t6_res_valid", {31'd0, res_valid}, 32'd0);
        check("t6_chk_vox", {17'd0, chk_vox}, 32'd0);
        check("t6_res_count", {28'd0, res_count}, 32'd0);
        start = 1'b1;
        tick();
        tick();
        check("t6_start_in_rst", {31'd0, busy}, 32'd0);
        start = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("t6_idle_after", {31'd0, busy}, 32'd0);
        exp_q.push_back('{mask: 8'h42, cnt: 4'd1});
        begin_sweep();
        send(15'h0042, 1'b1);
        wait_result("t6_valid");
        tick();
        tick();

        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prm_edge_sweep_ctrl.md
Name: prm_edge_sweep_ctrl

Overview:
- Sequences a bank of combinational PRM obstacle-check cells of the prm_oblgc_chkNNN family. Each cell takes a 15-bit voxel code (A..O) and returns one edge_mask bit.
- Accepts a stream of occupied-voxel codes for one sweep and presents each code to the whole bank.
- ORs the per-edge masks into a sticky collision vector, then hands the final per-edge blocked mask to the roadmap planner over a valid/ready port.
- Sits between the voxel-occupancy source and the graph-search logic.

Parameters:
- VOX_W, 15, voxel code width; drives checker inputs O..A, with bit VOX_W-1 = O.
- N_EDGE, 1024, number of checker cells (edges) in the bank; width of the mask vectors.
- CNT_W, 16, width of the voxel counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  one-cycle pulse; cancels the current sweep.
- busy  out  1  high from the start acceptance until the result handshake or abort.
- vox_valid  in  1  voxel code valid.
- vox_ready  out  1  controller accepts a voxel.
- vox_code  in  VOX_W  occupied-voxel code.
- vox_last  in  1  marks the final voxel of the sweep.
- chk_vox  out  VOX_W  registered code driven to all checker cells.
- chk_mask  in  N_EDGE  concatenated edge_mask outputs of the bank (combinational in chk_vox).
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_mask  out  N_EDGE  per-edge blocked mask; 1 = edge collides.
- res_count  out  CNT_W  number of voxels evaluated in the sweep.

Behaviour:
- Reset values:
  - State IDLE.
  - busy, vox_ready, res_valid = 0.
  - chk_vox, res_mask, res_count = 0.
  - Pipeline flag eval_v = 0.
- State machine: IDLE, CLEAR, SWEEP, DRAIN, DONE.
- IDLE:
  - vox_ready = 0.
  - start -> CLEAR.
  - Inputs vox_* are ignored.
- CLEAR (1 cycle):
  - res_mask <= 0, res_count <= 0, busy = 1.
  - Next state SWEEP.
- SWEEP:
  - vox_ready = 1.
  - On vox_valid & vox_ready: chk_vox <= vox_code, eval_v <= 1.
  - Otherwise eval_v <= 0; chk_vox holds its value.
  - A handshake with vox_last = 1 -> DRAIN.
- Evaluation latency:
  - A voxel accepted at edge k is on chk_vox during cycle k..k+1.
  - At edge k+1, if eval_v: res_mask <= res_mask | chk_mask, and res_count increments, saturating at 2^CNT_W-1.
  - Back-to-back voxels sustain 1 voxel per cycle; the bank is assumed to settle within one clock.
- DRAIN (1 cycle):
  - vox_ready = 0.
  - Performs the accumulation for the last voxel; eval_v <= 0.
  - Next state DONE.
- DONE:
  - res_valid = 1; res_mask and res_count are stable.
  - On res_ready -> IDLE with busy = 0 and res_valid = 0 on the following cycle.
  - res_mask and res_count hold their values in IDLE until the next CLEAR.
- start while busy: ignored, no restart.
- start and abort in the same IDLE cycle: abort wins, stay in IDLE.
- abort in CLEAR, SWEEP, DRAIN or DONE:
  - Next state IDLE; vox_ready, res_valid, busy and eval_v go to 0 next cycle.
  - res_mask and res_count are not cleared, but are invalid.
  - An in-flight evaluation is discarded.
- Reset mid-sweep: asynchronous return to reset values. Any upstream voxel transfer not yet handshaken is lost; upstream must restart.
- Sweeps are non-empty: a sweep ends only on vox_last. vox_last on the first voxel gives res_count = 1.
- The mask is monotone within a sweep: bits only set, never cleared.

Decomposition:
- Package prm_sweep_pkg holds:
  - VOX_W default;
  - the state enum (IDLE, CLEAR, SWEEP, DRAIN, DONE);
  - the CNT_MAX constant.
- One sub-module, prm_mask_accum: eval_v-gated OR-accumulator with clear, plus the saturating counter.
- The checker bank is instantiated outside this block; the controller only drives chk_vox and samples chk_mask.

Test Plan:
Bench: N_EDGE = 8, CNT_W = 4, behavioural bank model with chk_mask = chk_vox[7:0].
- Single sweep: start, then voxels 0x0003, 0x0010, 0x0080 (last on the third), res_ready = 1 -> res_valid 2 cycles after the last handshake, res_mask = 0x93, res_count = 3, busy low one cycle later.
- Back-to-back stream: 5 voxels with vox_valid held high, codes 0x01, 0x02, 0x04, 0x08, 0x10 -> vox_ready continuously high, res_mask = 0x1F, res_count = 5, no bubbles.
- Backpressure and gaps: vox_valid toggled 1,0,1 and res_ready held low for 4 cycles in DONE -> res_valid and res_mask stable for all 4 cycles; accumulation only on handshake cycles.
- Abort mid-sweep: abort 1 cycle after the 2nd voxel handshake -> IDLE next cycle, res_valid never asserts; a new sweep then starts with res_mask cleared to 0 in CLEAR.
- Counter saturation: 20 voxels of code 0x00 -> res_count = 15, res_mask = 0x00.
- Async reset asserted in SWEEP between clock edges -> all outputs 0 immediately; start ignored while rst_n is low; a start after release proceeds normally.
